// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: UART transceiver with RX/TX FIFOs,
// runtime echo-back, optional parity and line inversion.

module uart_echo_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0])
                && (wptr_q[AW] != rptr_q[AW]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  // wrapping read/write pointers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end
endmodule

module uart_echo_fifo #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16,
  parameter int INVERT_RX = 1,
  parameter int INVERT_TX = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 echo_en,
  input  logic                 RxD,
  output logic                 TxD,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_overflow,
  output logic                 echo_drop
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_FULL = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic HAS_PAR   = logic'(PARITY != 0);
  localparam logic ODD       = logic'(PARITY == 2);
  localparam logic LAST_STOP = logic'(STOP_BITS == 2);
  localparam logic INV_RX    = logic'(INVERT_RX != 0);
  localparam logic INV_TX    = logic'(INVERT_TX != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  logic                 rx_meta_q, rxs_q, rxs_prev_q;
  state_e               rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_par_q;
  logic                 rx_good_q;
  logic                 frame_err_q, parity_err_q;
  logic                 rx_par_bad;
  logic                 rx_full, rx_empty;

  state_e               tx_state_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q;
  logic                 tx_stop_q;
  logic                 txd_q;
  logic                 tx_line;
  logic                 tx_last_stop;
  logic                 tx_pop;
  logic                 tx_push;
  logic [DATA_BITS-1:0] tx_wdata;
  logic [DATA_BITS-1:0] tx_rdata;
  logic                 tx_full, tx_empty;

  // two-flop synchroniser plus previous sample for edge detect
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= RxD ^ INV_RX;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign rx_par_bad = HAS_PAR && ((^rx_sh_q ^ rx_par_q) != ODD);

  // receive FSM with registered disposal strobes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_par_q     <= 1'b0;
      rx_good_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_good_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      unique case (rx_state_q)
        S_START: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end else if (!rxs_q) begin
            rx_state_q <= S_DATA;
            rx_cnt_q   <= CNT_FULL;
            rx_bit_q   <= '0;
          end else begin
            rx_state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end else begin
            rx_sh_q  <= {rxs_q, rx_sh_q[DATA_BITS-1:1]};
            rx_cnt_q <= CNT_FULL;
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == LAST_BIT)
              rx_state_q <= HAS_PAR ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end else begin
            rx_par_q   <= rxs_q;
            rx_cnt_q   <= CNT_FULL;
            rx_state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end else begin
            rx_state_q <= S_IDLE;
            if (!rxs_q)          frame_err_q  <= 1'b1;
            else if (rx_par_bad) parity_err_q <= 1'b1;
            else                 rx_good_q    <= 1'b1;
          end
        end
        default: begin
          if (rxs_prev_q && !rxs_q) begin
            rx_state_q <= S_START;
            rx_cnt_q   <= CNT_HALF;
          end
        end
      endcase
    end
  end

  uart_echo_fifo_buf #(.W(DATA_BITS), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (rx_good_q),
    .wdata_i (rx_sh_q),
    .pop_i   (rx_ready),
    .rdata_o (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign rx_valid    = ~rx_empty;
  assign rx_overflow = rx_good_q & rx_full;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;

  assign tx_ready  = ~tx_full & ~echo_en;
  assign tx_push   = echo_en ? rx_good_q : tx_valid;
  assign tx_wdata  = echo_en ? rx_sh_q : tx_data;
  assign echo_drop = rx_good_q & echo_en & tx_full;

  uart_echo_fifo_buf #(.W(DATA_BITS), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (tx_push),
    .wdata_i (tx_wdata),
    .pop_i   (tx_pop),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  assign tx_last_stop = (tx_state_q == S_STOP) && (tx_cnt_q == '0)
                     && (tx_stop_q == LAST_STOP);
  assign tx_pop = ~tx_empty & ((tx_state_q == S_IDLE) | tx_last_stop);

  // logical line level for the current transmit state
  always_comb begin
    tx_line = 1'b1;
    unique case (tx_state_q)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_sh_q[0];
      S_PARITY: tx_line = tx_par_q;
      default:  tx_line = 1'b1;
    endcase
  end

  // transmit FSM; a pop in the last stop cycle chains frames gap-free
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      txd_q      <= ~INV_TX;
    end else begin
      txd_q <= tx_line ^ INV_TX;
      if (tx_pop) begin
        tx_state_q <= S_START;
        tx_cnt_q   <= CNT_FULL;
        tx_sh_q    <= tx_rdata;
        tx_par_q   <= ^tx_rdata ^ ODD;
      end else begin
        unique case (tx_state_q)
          S_START: begin
            if (tx_cnt_q != '0) begin
              tx_cnt_q <= tx_cnt_q - CW'(1);
            end else begin
              tx_state_q <= S_DATA;
              tx_cnt_q   <= CNT_FULL;
              tx_bit_q   <= '0;
            end
          end
          S_DATA: begin
            if (tx_cnt_q != '0) begin
              tx_cnt_q <= tx_cnt_q - CW'(1);
            end else begin
              tx_sh_q  <= tx_sh_q >> 1;
              tx_cnt_q <= CNT_FULL;
              tx_bit_q <= tx_bit_q + 3'd1;
              if (tx_bit_q == LAST_BIT) begin
                tx_state_q <= HAS_PAR ? S_PARITY : S_STOP;
                tx_stop_q  <= 1'b0;
              end
            end
          end
          S_PARITY: begin
            if (tx_cnt_q != '0) begin
              tx_cnt_q <= tx_cnt_q - CW'(1);
            end else begin
              tx_state_q <= S_STOP;
              tx_cnt_q   <= CNT_FULL;
              tx_stop_q  <= 1'b0;
            end
          end
          S_STOP: begin
            if (tx_cnt_q != '0) begin
              tx_cnt_q <= tx_cnt_q - CW'(1);
            end else if (tx_stop_q == LAST_STOP) begin
              tx_state_q <= S_IDLE;
            end else begin
              tx_stop_q <= 1'b1;
              tx_cnt_q  <= CNT_FULL;
            end
          end
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign TxD = txd_q;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed checks on an 8N1 instance
// and an 8E1 receive instance, 10 clocks per bit.
module tb_uart_echo_fifo;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rx_data_n, tx_data_n = 8'h00;
  logic rx_valid_n, rx_ready_n = 1'b0;
  logic tx_valid_n = 1'b0, tx_ready_n;
  logic echo_en_n = 1'b0, rxd_n = 1'b1, txd_n;
  logic perr_n, ferr_n, ovf_n, drop_n;

  logic [7:0] rx_data_e, tx_data_e = 8'h00;
  logic rx_valid_e, rx_ready_e = 1'b0;
  logic tx_valid_e = 1'b0, tx_ready_e;
  logic echo_en_e = 1'b0, rxd_e = 1'b1, txd_e;
  logic perr_e, ferr_e, ovf_e, drop_e;

  int tests = 0;
  int fails = 0;

  int ferr_c = 0, perr_n_c = 0, ovf_c = 0, drop_c = 0;
  int txrdy_c = 0, txlow_c = 0, perr_e_c = 0, vld_e_c = 0;

  uart_echo_fifo #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .DEPTH(4),
    .INVERT_RX(0), .INVERT_TX(0)
  ) u_n (
    .clk(clk), .n_rst(n_rst),
    .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
    .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
    .echo_en(echo_en_n), .RxD(rxd_n), .TxD(txd_n),
    .parity_err(perr_n), .frame_err(ferr_n),
    .rx_overflow(ovf_n), .echo_drop(drop_n)
  );

  uart_echo_fifo #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .DEPTH(4),
    .INVERT_RX(0), .INVERT_TX(0)
  ) u_e (
    .clk(clk), .n_rst(n_rst),
    .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
    .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
    .echo_en(echo_en_e), .RxD(rxd_e), .TxD(txd_e),
    .parity_err(perr_e), .frame_err(ferr_e),
    .rx_overflow(ovf_e), .echo_drop(drop_e)
  );

  always @(negedge clk) begin
    if (ferr_n) ferr_c++;
    if (perr_n) perr_n_c++;
    if (ovf_n) ovf_c++;
    if (drop_n) drop_c++;
    if (tx_ready_n) txrdy_c++;
    if (!txd_n) txlow_c++;
    if (perr_e) perr_e_c++;
    if (rx_valid_e) vld_e_c++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input bit sel_e, input logic v);
    if (sel_e) rxd_e = v;
    else rxd_n = v;
    tick(10);
  endtask

  task automatic rx_send(input bit sel_e, input logic [7:0] d,
                         input bit use_par, input logic pbit,
                         input logic stopv);
    drive_bit(sel_e, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel_e, d[i]);
    if (use_par) drive_bit(sel_e, pbit);
    drive_bit(sel_e, stopv);
    if (sel_e) rxd_e = 1'b1;
    else rxd_n = 1'b1;
  endtask

  task automatic tx_capture(output logic [7:0] b, output bit ok);
    int w;
    b = 8'h00;
    ok = 1'b0;
    w = 0;
    while (txd_n !== 1'b0 && w < 400) begin
      tick(1);
      w++;
    end
    if (txd_n !== 1'b0) return;
    tick(5);
    for (int i = 0; i < 8; i++) begin
      tick(10);
      b[i] = txd_n;
    end
    tick(10);
    ok = (txd_n === 1'b1);
  endtask

  task automatic pop_n();
    rx_ready_n = 1'b1;
    tick(1);
    rx_ready_n = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick(2);
    tests++;
    if (rx_valid_n !== 1'b0) begin
      fails++;
      $display("FAIL reset_rx_valid: got %b want 0", rx_valid_n);
    end
    tests++;
    if (txd_n !== 1'b1 || txd_e !== 1'b1) begin
      fails++;
      $display("FAIL reset_txd: got %b/%b want 1/1", txd_n, txd_e);
    end
    tests++;
    if (tx_ready_n !== 1'b1) begin
      fails++;
      $display("FAIL reset_tx_ready: got %b want 1", tx_ready_n);
    end
    tests++;
    if ({perr_n, ferr_n, ovf_n, drop_n} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_pulses: got %b want 0000",
               {perr_n, ferr_n, ovf_n, drop_n});
    end
    n_rst = 1'b1;
    tick(3);
    tests++;
    if (txd_n !== 1'b1 || rx_valid_e !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: txd %b rx_valid_e %b want 1 0",
               txd_n, rx_valid_e);
    end
  endtask

  task automatic test_tx_8n1();
    logic [9:0] exp;
    int bad;
    int rbad;
    exp = {1'b1, 8'h55, 1'b0};
    rbad = 0;
    tx_data_n = 8'h55;
    tx_valid_n = 1'b1;
    tests++;
    if (tx_ready_n !== 1'b1) begin
      fails++;
      $display("FAIL tx_ready_idle: got %b want 1", tx_ready_n);
    end
    tick(1);
    tx_valid_n = 1'b0;
    tick(1);
    tests++;
    if (txd_n !== 1'b1) begin
      fails++;
      $display("FAIL tx_start_early: got %b want 1 at N+1", txd_n);
    end
    tick(1);
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < 10; c++) begin
        if (txd_n !== exp[k]) bad++;
        if (tx_ready_n !== 1'b1) rbad++;
        tick(1);
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL tx_bit%0d: %0d cycles wrong, want level %b",
                 k, bad, exp[k]);
      end
    end
    tests++;
    if (rbad != 0) begin
      fails++;
      $display("FAIL tx_ready_hold: %0d low cycles want 0", rbad);
    end
  endtask

  task automatic test_rx_8e1();
    int p0;
    int v0;
    p0 = perr_e_c;
    rx_send(1'b1, 8'hA3, 1'b1, 1'b0, 1'b1);
    tick(3);
    tests++;
    if (rx_valid_e !== 1'b1 || rx_data_e !== 8'hA3) begin
      fails++;
      $display("FAIL rx8e1_good: valid %b data %h want 1 a3",
               rx_valid_e, rx_data_e);
    end
    tests++;
    if (perr_e_c != p0) begin
      fails++;
      $display("FAIL rx8e1_no_perr: got %0d pulses want 0", perr_e_c - p0);
    end
    rx_ready_e = 1'b1;
    tick(1);
    rx_ready_e = 1'b0;
    tests++;
    if (rx_valid_e !== 1'b0) begin
      fails++;
      $display("FAIL rx8e1_pop: valid %b want 0", rx_valid_e);
    end
    p0 = perr_e_c;
    v0 = vld_e_c;
    rx_send(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1);
    tick(3);
    tests++;
    if (perr_e_c - p0 != 1) begin
      fails++;
      $display("FAIL rx8e1_perr: got %0d pulses want 1", perr_e_c - p0);
    end
    tests++;
    if (vld_e_c != v0) begin
      fails++;
      $display("FAIL rx8e1_bad_valid: %0d valid cycles want 0",
               vld_e_c - v0);
    end
  endtask

  task automatic test_echo();
    logic [7:0] exp [3];
    logic [7:0] got [3];
    bit ok [3];
    int r0;
    int d0;
    int l0;
    exp[0] = 8'h11;
    exp[1] = 8'h22;
    exp[2] = 8'h33;
    echo_en_n = 1'b1;
    tx_data_n = 8'hEE;
    tx_valid_n = 1'b1;
    r0 = txrdy_c;
    d0 = drop_c;
    fork
      begin
        for (int i = 0; i < 3; i++)
          rx_send(1'b0, exp[i], 1'b0, 1'b0, 1'b1);
      end
      begin
        for (int j = 0; j < 3; j++) tx_capture(got[j], ok[j]);
      end
    join
    l0 = txlow_c;
    tick(150);
    tx_valid_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (!ok[i] || got[i] !== exp[i]) begin
        fails++;
        $display("FAIL echo_byte%0d: got %h ok %b want %h",
                 i, got[i], ok[i], exp[i]);
      end
    end
    tests++;
    if (txrdy_c != r0) begin
      fails++;
      $display("FAIL echo_tx_ready: %0d high cycles want 0", txrdy_c - r0);
    end
    tests++;
    if (drop_c != d0 || txlow_c != l0) begin
      fails++;
      $display("FAIL echo_extra: drops %0d low cycles %0d want 0 0",
               drop_c - d0, txlow_c - l0);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rx_valid_n !== 1'b1 || rx_data_n !== exp[i]) begin
        fails++;
        $display("FAIL echo_rxfifo%0d: valid %b data %h want 1 %h",
                 i, rx_valid_n, rx_data_n, exp[i]);
      end
      pop_n();
    end
    echo_en_n = 1'b0;
    tests++;
    if (rx_valid_n !== 1'b0) begin
      fails++;
      $display("FAIL echo_rx_empty: valid %b want 0", rx_valid_n);
    end
  endtask

  task automatic test_overflow();
    int o0;
    logic [7:0] want;
    o0 = ovf_c;
    for (int i = 1; i <= 4; i++)
      rx_send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
    tick(3);
    tests++;
    if (ovf_c != o0) begin
      fails++;
      $display("FAIL ovf_early: got %0d pulses want 0", ovf_c - o0);
    end
    rx_send(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
    tick(3);
    tests++;
    if (ovf_c - o0 != 1) begin
      fails++;
      $display("FAIL ovf_byte5: got %0d pulses want 1", ovf_c - o0);
    end
    for (int i = 1; i <= 4; i++) begin
      want = 8'(i);
      tests++;
      if (rx_valid_n !== 1'b1 || rx_data_n !== want) begin
        fails++;
        $display("FAIL ovf_pop%0d: valid %b data %h want 1 %h",
                 i, rx_valid_n, rx_data_n, want);
      end
      pop_n();
    end
    tests++;
    if (rx_valid_n !== 1'b0) begin
      fails++;
      $display("FAIL ovf_empty: valid %b want 0", rx_valid_n);
    end
  endtask

  task automatic test_glitch_frame();
    int f0;
    int p0;
    int o0;
    f0 = ferr_c;
    p0 = perr_n_c;
    o0 = ovf_c;
    rxd_n = 1'b0;
    tick(3);
    rxd_n = 1'b1;
    tick(30);
    tests++;
    if (ferr_c != f0 || perr_n_c != p0 || ovf_c != o0) begin
      fails++;
      $display("FAIL glitch_pulses: ferr %0d perr %0d ovf %0d want 0",
               ferr_c - f0, perr_n_c - p0, ovf_c - o0);
    end
    tests++;
    if (rx_valid_n !== 1'b0) begin
      fails++;
      $display("FAIL glitch_valid: got %b want 0", rx_valid_n);
    end
    rx_send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    tick(3);
    tests++;
    if (ferr_c - f0 != 1) begin
      fails++;
      $display("FAIL frame_err: got %0d pulses want 1", ferr_c - f0);
    end
    tests++;
    if (rx_valid_n !== 1'b0) begin
      fails++;
      $display("FAIL frame_push: valid %b want 0", rx_valid_n);
    end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] fr;
    logic [7:0] got;
    bit ok;
    int f0;
    fr = {8'h3C, 1'b0};
    for (int c = 0; c < 66; c++) begin
      rxd_n = fr[c/10];
      if (c == 20) begin
        tx_data_n = 8'h00;
        tx_valid_n = 1'b1;
      end
      if (c == 21) tx_valid_n = 1'b0;
      tick(1);
    end
    tests++;
    if (txd_n !== 1'b0) begin
      fails++;
      $display("FAIL rst_tx_bit3: got %b want 0", txd_n);
    end
    n_rst = 1'b0;
    rxd_n = 1'b1;
    #1;
    tests++;
    if (txd_n !== 1'b1) begin
      fails++;
      $display("FAIL rst_txd_idle: got %b want 1", txd_n);
    end
    tick(3);
    n_rst = 1'b1;
    f0 = ferr_c;
    tick(120);
    tests++;
    if (rx_valid_n !== 1'b0 || ferr_c != f0) begin
      fails++;
      $display("FAIL rst_rx_discard: valid %b ferr %0d want 0 0",
               rx_valid_n, ferr_c - f0);
    end
    tx_data_n = 8'hC3;
    tx_valid_n = 1'b1;
    tick(1);
    tx_valid_n = 1'b0;
    tx_capture(got, ok);
    tests++;
    if (!ok || got !== 8'hC3) begin
      fails++;
      $display("FAIL rst_tx_after: got %h ok %b want c3", got, ok);
    end
  endtask

  initial begin
    test_reset();
    test_tx_8n1();
    test_rx_8e1();
    test_echo();
    test_overflow();
    test_glitch_frame();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
